count_seq_checker: RTL and testbench
====================================

Name: count_seq_checker

Overview:
- Receive-side monitor for the 4-bit wrap-at-MAX_COUNT counter output (sequence 0,1,...,MAX_COUNT,0,...).
- Samples the count bus on `valid`, acquires lock onto the sequence and flags every out-of-sequence sample.
- Keeps saturating error and wrap statistics.
- Sits next to the counter in the self-check path; status is read by software or the testbench.

Parameters:
- MAX_COUNT, 13: terminal value of the monitored sequence; legal range 1..15.
- LOCK_LEN, 2: consecutive correct transitions required to enter LOCKED; legal range 1..7.
- ERR_W, 8: width of err_count.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- count_in  input  4  monitored count value
- valid  input  1  count_in is sampled this cycle when high
- clear  input  1  synchronous clear of err_count and wrap_count; FSM unaffected
- locked  output  1  high while FSM is in LOCKED
- error_pulse  output  1  one-cycle pulse, cycle after a mismatching sample in LOCKED
- err_count  output  ERR_W  number of mismatches, saturating at all-ones
- wrap_count  output  8  number of MAX_COUNT->0 transitions seen while LOCKED, wraps modulo 256
- expected  output  4  next value the checker expects; valid only when locked

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE; prev=0; match_cnt=0; locked=0; error_pulse=0; err_count=0; wrap_count=0; expected=0.
- nxt(x) = (x==MAX_COUNT) ? 0 : x+1, computed in 4 bits.
- A value greater than MAX_COUNT never equals nxt(anything) and is always a mismatch.
- All outputs are registered; every effect of a sample at edge N is visible after edge N.
- valid=0: no state change except clear handling; error_pulse=0.
- FSM IDLE, on valid: prev<=count_in; match_cnt<=0; go to ACQUIRE.
- FSM ACQUIRE, on valid:
  - count_in==nxt(prev): match_cnt++. If match_cnt+1==LOCK_LEN, go to LOCKED with locked=1 and expected<=nxt(count_in).
  - Otherwise: match_cnt<=0, stay in ACQUIRE.
  - In both cases prev<=count_in.
  - No error_pulse and no err_count change in ACQUIRE.
- FSM LOCKED, on valid:
  - count_in==expected: prev<=count_in; expected<=nxt(count_in). If prev==MAX_COUNT and count_in==0, wrap_count++.
  - Mismatch: error_pulse=1 for one cycle; err_count++ (holds at all-ones); locked<=0; go to ACQUIRE; match_cnt<=0; prev<=count_in. Resynchronisation restarts from the bad sample.
- clear=1: err_count<=0 and wrap_count<=0. Clear has priority over an increment in the same cycle; error_pulse and the FSM still act normally.
- Consecutive valid cycles are not required; gaps of any length are ignored and the sequence continues across them.
- Reset asserted mid-operation returns everything to reset values immediately, independent of clk.
- The first sample after reset deassertion is accepted only on a clean edge; no action is taken while rst=0.

Test Plan:
1. Lock and wrap: reset, then valid=1 every cycle with count_in=0..13 repeating for 3 periods. Required: locked=1 after the 3rd sample (LOCK_LEN=2); error_pulse never asserts; err_count=0; wrap_count=2 after the last 13->0 transition seen while locked.
2. Single glitch: locked on a running sequence, inject count_in=9 where 6 is expected, then resume 7,8,9... Required: error_pulse high for exactly one cycle; err_count=1; locked=0. 7 counts as a mismatch against nxt(9)=10 in ACQUIRE; locked returns after 8,9 (two correct transitions following 7).
3. Out-of-range value: locked, with count_in=15 presented. Required: mismatch, err_count increments. In ACQUIRE, 15 followed by 0 is not a match because nxt(15)=0 is never legal; match_cnt stays 0 until a valid pair is seen.
4. Gapped valid: sequence 0..13 with valid low for 1-5 random cycles between samples. Required: same results as scenario 1; no errors.
5. Saturation and clear: ERR_W=2, force 5 mismatches. Required: err_count=3 (holds). Then clear=1 in the same cycle as a mismatch: err_count=0, error_pulse=1.
6. Async reset mid-run: locked with err_count=2 and wrap_count=4, drop rst between clock edges. Required: all outputs 0 immediately. After release the FSM is in IDLE and needs 3 valid correct samples to relock.

Source files
------------

// File: rtl/count_seq_checker.sv
// ----------------------------------------------------------------------------
// count_seq_checker
//
// Receive-side monitor for a 4-bit counter that runs 0,1,...,MAX_COUNT,0,...
// Every cycle with `valid` high, count_in is sampled and compared against the
// sequence. The checker first acquires lock (LOCK_LEN consecutive correct
// transitions). Once locked, it flags every out-of-sequence sample and counts
// wraps. A mismatch drops the lock, and resynchronisation starts from the bad
// sample itself.
//
// Parameters:
//   MAX_COUNT  terminal value of the monitored sequence (1..15)
//   LOCK_LEN   consecutive correct transitions needed to lock (1..7)
//   ERR_W      width of err_count
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   count_in     in   [3:0] monitored count value
//   valid        in   count_in is sampled this cycle when high
//   clear        in   synchronous clear of err_count / wrap_count (FSM unaffected)
//   locked       out  high while the checker is locked onto the sequence
//   error_pulse  out  one-cycle pulse after a mismatching sample while locked
//   err_count    out  [ERR_W-1:0] saturating mismatch counter
//   wrap_count   out  [7:0] MAX_COUNT->0 transitions seen while locked (mod 256)
//   expected     out  [3:0] next value the checker expects (meaningful when locked)
// ----------------------------------------------------------------------------
module count_seq_checker #(
    parameter int unsigned MAX_COUNT = 13,
    parameter int unsigned LOCK_LEN  = 2,
    parameter int unsigned ERR_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       count_in,
    input  logic             valid,
    input  logic             clear,
    output logic             locked,
    output logic             error_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       wrap_count,
    output logic [3:0]       expected
);

    localparam logic [3:0] MAX_V  = MAX_COUNT[3:0];
    localparam logic [3:0] LOCK_V = LOCK_LEN[3:0];

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       prev_q, prev_d;
    logic [2:0]       match_q, match_d;
    logic             locked_q, locked_d;
    logic             pulse_q, pulse_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [7:0]       wrap_q, wrap_d;
    logic [3:0]       expected_q, expected_d;

    logic             err_inc;
    logic             wrap_inc;
    logic             pair_ok;
    logic [3:0]       match_next;

    // Successor of a sequence value, computed in 4 bits.
    function automatic logic [3:0] nxt(input logic [3:0] x);
        return (x == MAX_V) ? 4'd0 : x + 4'd1;
    endfunction

    // During acquisition a transition only counts when both values are legal
    // members of the sequence. The plain 4-bit successor of 15 is 0, so
    // without the range test on prev the pair 15->0 would be taken as
    // correct.
    assign pair_ok    = (prev_q <= MAX_V) && (count_in <= MAX_V) && (count_in == nxt(prev_q));
    assign match_next = {1'b0, match_q} + 4'd1;

    // Next-state logic. Every register holds its value by default. A sample
    // is acted on only when valid is high. Statistics counters are handled
    // after the FSM so that clear can override any increment requested in
    // the same cycle.
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        match_d    = match_q;
        locked_d   = locked_q;
        expected_d = expected_q;
        pulse_d    = 1'b0;
        err_inc    = 1'b0;
        wrap_inc   = 1'b0;

        if (valid) begin
            case (state_q)
                IDLE: begin
                    prev_d  = count_in;
                    match_d = 3'd0;
                    state_d = ACQUIRE;
                end

                ACQUIRE: begin
                    prev_d = count_in;
                    if (pair_ok) begin
                        match_d = match_next[2:0];
                        if (match_next == LOCK_V) begin
                            state_d    = LOCKED;
                            locked_d   = 1'b1;
                            expected_d = nxt(count_in);
                        end
                    end else begin
                        match_d = 3'd0;
                    end
                end

                LOCKED: begin
                    prev_d = count_in;
                    if (count_in == expected_q) begin
                        expected_d = nxt(count_in);
                        if ((prev_q == MAX_V) && (count_in == 4'd0)) begin
                            wrap_inc = 1'b1;
                        end
                    end else begin
                        pulse_d  = 1'b1;
                        err_inc  = 1'b1;
                        locked_d = 1'b0;
                        match_d  = 3'd0;
                        state_d  = ACQUIRE;
                    end
                end

                default: begin
                    state_d  = IDLE;
                    locked_d = 1'b0;
                    match_d  = 3'd0;
                end
            endcase
        end
    end

    // Statistics. The error counter sticks at all-ones. The wrap counter
    // rolls over freely. Clear wins over an increment in the same cycle.
    always_comb begin
        err_d  = err_q;
        wrap_d = wrap_q;
        if (clear) begin
            err_d  = '0;
            wrap_d = 8'd0;
        end else begin
            if (err_inc && !(&err_q)) begin
                err_d = err_q + ERR_W'(1);
            end
            if (wrap_inc) begin
                wrap_d = wrap_q + 8'd1;
            end
        end
    end

    // State register. All outputs come straight from these flops. Reset is
    // asynchronous and active low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            prev_q     <= 4'd0;
            match_q    <= 3'd0;
            locked_q   <= 1'b0;
            pulse_q    <= 1'b0;
            err_q      <= '0;
            wrap_q     <= 8'd0;
            expected_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            match_q    <= match_d;
            locked_q   <= locked_d;
            pulse_q    <= pulse_d;
            err_q      <= err_d;
            wrap_q     <= wrap_d;
            expected_q <= expected_d;
        end
    end

    assign locked      = locked_q;
    assign error_pulse = pulse_q;
    assign err_count   = err_q;
    assign wrap_count  = wrap_q;
    assign expected    = expected_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// ----------------------------------------------------------------------------
// tb_count_seq_checker
//
// Directed bench for count_seq_checker (MAX_COUNT=13, LOCK_LEN=2, ERR_W=2).
// Inputs are driven on the falling edge. Outputs are checked 1 time unit
// after the rising edge that consumed them.
// ----------------------------------------------------------------------------
module tb_count_seq_checker;

    localparam int MAX_COUNT = 13;
    localparam int LOCK_LEN  = 2;
    localparam int ERR_W     = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [3:0]       count_in = 4'd0;
    logic             valid = 1'b0;
    logic             clear = 1'b0;
    logic             locked;
    logic             error_pulse;
    logic [ERR_W-1:0] err_count;
    logic [7:0]       wrap_count;
    logic [3:0]       expected;

    int checks = 0;
    int errors = 0;

    count_seq_checker #(
        .MAX_COUNT (MAX_COUNT),
        .LOCK_LEN  (LOCK_LEN),
        .ERR_W     (ERR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .count_in    (count_in),
        .valid       (valid),
        .clear       (clear),
        .locked      (locked),
        .error_pulse (error_pulse),
        .err_count   (err_count),
        .wrap_count  (wrap_count),
        .expected    (expected)
    );

    always #5 clk = ~clk;

    // Watchdog in case something unexpected stalls the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Successor of a value in the monitored sequence
    function automatic logic [3:0] seq_next(input int v);
        return (v == MAX_COUNT) ? 4'd0 : 4'(v + 1);
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] required);
        checks++;
        assert (observed === required) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d required=%0d", tag, observed, required);
        end
    endtask

    task automatic checkStatus(input string tag, input logic lk, input logic ep,
                               input logic [7:0] ec, input logic [7:0] wc);
        checkOutput({tag, "_locked"}, 8'(locked), 8'(lk));
        checkOutput({tag, "_pulse"}, 8'(error_pulse), 8'(ep));
        checkOutput({tag, "_err"}, 8'(err_count), ec);
        checkOutput({tag, "_wrap"}, wrap_count, wc);
    endtask

    // Drive one cycle of inputs, then settle just after the rising edge
    task automatic applyStimulus(input logic v, input logic [3:0] c, input logic clr);
        @(negedge clk);
        valid    = v;
        count_in = c;
        clear    = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [3:0] c);
        applyStimulus(1'b1, c, 1'b0);
    endtask

    logic [3:0] bad_vals [5];
    logic [7:0] err_after [5];
    logic       exp_lock;

    initial begin
        bad_vals  = '{4'd5, 4'd1, 4'd9, 4'd0, 4'd7};
        err_after = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        checkStatus("reset", 1'b0, 1'b0, 8'd0, 8'd0);
        checkOutput("reset_expected", 8'(expected), 8'd0);
        @(negedge clk);
        rst = 1'b1;

        // ---------------- scenario 1: lock and wrap ----------------
        for (int p = 0; p < 3; p++) begin
            for (int v = 0; v <= MAX_COUNT; v++) begin
                sample(4'(v));
                exp_lock = ((p * 14 + v) >= 2);
                checkOutput("s1_locked", 8'(locked), 8'(exp_lock));
                checkOutput("s1_pulse", 8'(error_pulse), 8'd0);
                if (exp_lock) checkOutput("s1_expected", 8'(expected), 8'(seq_next(v)));
            end
        end
        checkStatus("s1_end", 1'b1, 1'b0, 8'd0, 8'd2);

        // ---------------- scenario 2: single glitch ----------------
        for (int v = 0; v <= 5; v++) sample(4'(v));
        checkStatus("s2_pre", 1'b1, 1'b0, 8'd0, 8'd3);
        sample(4'd9);
        checkStatus("s2_glitch", 1'b0, 1'b1, 8'd1, 8'd3);
        sample(4'd7);
        checkStatus("s2_after7", 1'b0, 1'b0, 8'd1, 8'd3);
        sample(4'd8);
        checkStatus("s2_after8", 1'b0, 1'b0, 8'd1, 8'd3);
        sample(4'd9);
        checkStatus("s2_relock", 1'b1, 1'b0, 8'd1, 8'd3);
        checkOutput("s2_expected", 8'(expected), 8'd10);
        for (int v = 10; v <= MAX_COUNT; v++) sample(4'(v));
        checkStatus("s2_end", 1'b1, 1'b0, 8'd1, 8'd3);

        // ---------------- scenario 3: out-of-range value ----------------
        sample(4'd15);
        checkStatus("s3_oor", 1'b0, 1'b1, 8'd2, 8'd3);
        sample(4'd0);
        checkStatus("s3_after0", 1'b0, 1'b0, 8'd2, 8'd3);
        sample(4'd1);
        checkStatus("s3_after1", 1'b0, 1'b0, 8'd2, 8'd3);
        sample(4'd2);
        checkStatus("s3_relock", 1'b1, 1'b0, 8'd2, 8'd3);
        checkOutput("s3_expected", 8'(expected), 8'd3);

        // ---------------- scenario 6: async reset mid-run ----------------
        for (int v = 3; v <= MAX_COUNT; v++) sample(4'(v));
        sample(4'd0);
        checkStatus("s6_pre", 1'b1, 1'b0, 8'd2, 8'd4);
        checkOutput("s6_pre_expected", 8'(expected), 8'd1);
        #2;
        valid = 1'b0;
        rst   = 1'b0;
        #1;
        checkStatus("s6_async", 1'b0, 1'b0, 8'd0, 8'd0);
        checkOutput("s6_async_expected", 8'(expected), 8'd0);
        @(negedge clk);
        rst = 1'b1;
        sample(4'd5);
        checkOutput("s6_relock1", 8'(locked), 8'd0);
        sample(4'd6);
        checkOutput("s6_relock2", 8'(locked), 8'd0);
        sample(4'd7);
        checkStatus("s6_relock3", 1'b1, 1'b0, 8'd0, 8'd0);
        checkOutput("s6_expected", 8'(expected), 8'd8);

        // ---------------- scenario 4: gapped valid ----------------
        @(negedge clk);
        valid = 1'b0;
        rst   = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("s4_reset_locked", 8'(locked), 8'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int p = 0; p < 3; p++) begin
            for (int v = 0; v <= MAX_COUNT; v++) begin
                sample(4'(v));
                exp_lock = ((p * 14 + v) >= 2);
                checkOutput("s4_locked", 8'(locked), 8'(exp_lock));
                checkOutput("s4_pulse", 8'(error_pulse), 8'd0);
                if (exp_lock) checkOutput("s4_expected", 8'(expected), 8'(seq_next(v)));
                repeat ($urandom_range(1, 5)) begin
                    applyStimulus(1'b0, 4'($urandom_range(0, 15)), 1'b0);
                end
                checkOutput("s4_gap_locked", 8'(locked), 8'(exp_lock));
                checkOutput("s4_gap_pulse", 8'(error_pulse), 8'd0);
            end
        end
        checkStatus("s4_end", 1'b1, 1'b0, 8'd0, 8'd2);
        checkOutput("s4_end_expected", 8'(expected), 8'd0);

        // ---------------- scenario 5: saturation and clear ----------------
        for (int i = 0; i < 5; i++) begin
            sample(bad_vals[i]);
            checkStatus("s5_bad", 1'b0, 1'b1, err_after[i], 8'd2);
            sample(bad_vals[i] + 4'd1);
            checkOutput("s5_acq_locked", 8'(locked), 8'd0);
            sample(bad_vals[i] + 4'd2);
            checkStatus("s5_relock", 1'b1, 1'b0, err_after[i], 8'd2);
            checkOutput("s5_expected", 8'(expected), 8'(bad_vals[i] + 4'd3));
        end
        applyStimulus(1'b1, 4'd2, 1'b1);
        checkStatus("s5_clear", 1'b0, 1'b1, 8'd0, 8'd0);
        applyStimulus(1'b0, 4'd0, 1'b0);
        checkStatus("s5_idle", 1'b0, 1'b0, 8'd0, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
